lfsr_pair_collector: RTL

//  Upstream feeder for the polynomial finder. Takes decoded 17-bit LFSR words with their
//  24-bit capture timestamps from the pulse decoder and pairs two consecutive words whose

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/ts_gap_check.sv | 26 ++
 rtl/lfsr_pair_collector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg
//  Brief    : Shared widths, gap limits and collector state encoding.
//  Revision : 1.0
// ============================================================================
package lfsr_pkg;

    localparam int TS_WIDTH   = 24;
    localparam int DATA_WIDTH = 17;

    localparam logic [TS_WIDTH-1:0] MIN_GAP_DEF = 24'd1000;
    localparam logic [TS_WIDTH-1:0] MAX_GAP_DEF = 24'd2000000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAVE_ONE = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Timestamps wrap, so the gap is the plain modular difference.
    function automatic logic [TS_WIDTH-1:0] ts_gap(
        input logic [TS_WIDTH-1:0] a,
        input logic [TS_WIDTH-1:0] b
    );
        return b - a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_gap_check.sv
`default_nettype none
// ============================================================================
//  Module   : ts_gap_check
//  Brief    : Modular timestamp gap against inclusive MIN/MAX window.
//  Revision : 1.0
// ============================================================================
module ts_gap_check
    import lfsr_pkg::*;
#(
    parameter logic [TS_WIDTH-1:0] MIN_GAP = MIN_GAP_DEF,
    parameter logic [TS_WIDTH-1:0] MAX_GAP = MAX_GAP_DEF
) (
    input  logic [TS_WIDTH-1:0] i_ts_a,
    input  logic [TS_WIDTH-1:0] i_ts_b,
    output logic                gap_ok,
    output logic                gap_late
);

    logic [TS_WIDTH-1:0] w_gap;

    assign w_gap    = ts_gap(i_ts_a, i_ts_b);
    assign gap_ok   = (w_gap >= MIN_GAP) && (w_gap <= MAX_GAP);
    assign gap_late = (w_gap > MAX_GAP);

endmodule
`default_nettype wire

// File: rtl/lfsr_pair_collector.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pair_collector
//  Brief    : Pairs consecutive LFSR words with plausible gap, holds the pair
//             for the polynomial finder. Optional PAIR_STATS_EN adds counters.
//  Revision : 1.0
// ============================================================================
module lfsr_pair_collector
    import lfsr_pkg::*;
#(
    parameter logic [TS_WIDTH-1:0] MIN_GAP = MIN_GAP_DEF,
    parameter logic [TS_WIDTH-1:0] MAX_GAP = MAX_GAP_DEF
) (
    input  logic                  clk_96MHz,
    input  logic                  reset,
    input  logic [TS_WIDTH-1:0]   sys_ts,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [TS_WIDTH-1:0]   ts_in,
    input  logic                  data_valid,
    input  logic                  poly_ready,
    output logic [DATA_WIDTH-1:0] decoded_data,
    output logic [TS_WIDTH-1:0]   ts_last_data,
    output logic [DATA_WIDTH-1:0] decoded_data1,
    output logic [TS_WIDTH-1:0]   ts_last_data1,
    output logic                  enable,
    output logic [7:0]            drop_count
`ifdef PAIR_STATS_EN
    ,
    output logic [15:0]           pairs_issued,
    output logic [7:0]            stale_count
`endif
);

    state_t r_state;
    state_t w_next_state;

    logic [DATA_WIDTH-1:0] r_data0;
    logic [TS_WIDTH-1:0]   r_ts0;
    logic [DATA_WIDTH-1:0] r_decoded_data;
    logic [TS_WIDTH-1:0]   r_ts_last_data;
    logic [DATA_WIDTH-1:0] r_decoded_data1;
    logic [TS_WIDTH-1:0]   r_ts_last_data1;
    logic                  r_enable;
    logic [7:0]            r_drop_count;

    logic w_word_ok;
    logic w_busy;
    logic w_drop;
    logic w_load_first;
    logic w_load_pair;
    logic w_stale;
    logic w_pair_ok;
    logic w_pair_late;
    logic w_stale_ok;
    logic w_stale_late;
    logic w_unused_gap;

    ts_gap_check #(
        .MIN_GAP (MIN_GAP),
        .MAX_GAP (MAX_GAP)
    ) u_pair_gap (
        .i_ts_a   (r_ts0),
        .i_ts_b   (ts_in),
        .gap_ok   (w_pair_ok),
        .gap_late (w_pair_late)
    );

    ts_gap_check #(
        .MIN_GAP (MIN_GAP),
        .MAX_GAP (MAX_GAP)
    ) u_stale_gap (
        .i_ts_a   (r_ts0),
        .i_ts_b   (sys_ts),
        .gap_ok   (w_stale_ok),
        .gap_late (w_stale_late)
    );

    assign w_unused_gap = w_pair_late | w_stale_ok;

    // A zero word is an illegal LFSR state and never enters the pairing logic.
    assign w_word_ok = data_valid && (data_in != '0);
    assign w_busy    = (r_state == ST_ISSUE) || (r_state == ST_RELEASE);
    assign w_drop    = data_valid && ((data_in == '0) || w_busy);

    always_comb begin
        w_next_state = r_state;
        w_load_first = 1'b0;
        w_load_pair  = 1'b0;
        w_stale      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_word_ok) begin
                    w_load_first = 1'b1;
                    w_next_state = ST_HAVE_ONE;
                end
            end
            ST_HAVE_ONE: begin
                if (w_word_ok) begin
                    if (w_pair_ok) begin
                        w_load_pair  = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_load_first = 1'b1;
                    end
                end else if (w_stale_late) begin
                    w_stale      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (poly_ready) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!poly_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_data0         <= '0;
            r_ts0           <= '0;
            r_decoded_data  <= '0;
            r_ts_last_data  <= '0;
            r_decoded_data1 <= '0;
            r_ts_last_data1 <= '0;
            r_enable        <= 1'b0;
            r_drop_count    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_enable <= (w_next_state == ST_ISSUE);
            if (w_load_first) begin
                r_data0 <= data_in;
                r_ts0   <= ts_in;
            end
            // Pair outputs only change on a new pair, so they stay held through ISSUE/RELEASE.
            if (w_load_pair) begin
                r_decoded_data  <= r_data0;
                r_ts_last_data  <= r_ts0;
                r_decoded_data1 <= data_in;
                r_ts_last_data1 <= ts_in;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

`ifdef PAIR_STATS_EN
    logic [15:0] r_pairs_issued;
    logic [7:0]  r_stale_count;

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            r_pairs_issued <= '0;
            r_stale_count  <= '0;
        end else begin
            if (w_load_pair) begin
                r_pairs_issued <= r_pairs_issued + 16'd1;
            end
            if (w_stale && (r_stale_count != 8'hFF)) begin
                r_stale_count <= r_stale_count + 8'd1;
            end
        end
    end

    assign pairs_issued = r_pairs_issued;
    assign stale_count  = r_stale_count;
`endif

    assign decoded_data  = r_decoded_data;
    assign ts_last_data  = r_ts_last_data;
    assign decoded_data1 = r_decoded_data1;
    assign ts_last_data1 = r_ts_last_data1;
    assign enable        = r_enable;
    assign drop_count    = r_drop_count;

endmodule
`default_nettype wire
